// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared constants and puncture tables for the OFDM transmit chain
package ofdm_tx_pkg;
  typedef enum logic [1:0] {R12 = 2'b00, R23 = 2'b01, R34 = 2'b10, R12X = 2'b11} rate_e;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;
  localparam int TAIL_LEN = 6;
  function automatic logic [1:0] keep_mask(input logic [1:0] r, input logic [1:0] p);
    return (r == R12 || r == R12X || p == 2'd0) ? 2'b11 : (p == 2'd1) ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [1:0] phase_last(input logic [1:0] r);
    return (r == R23) ? 2'd1 : (r == R34) ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: K=7 133/171 encoder taps with a clearable shift register
module conv_enc_core
  import ofdm_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic u,
  output logic a,
  output logic b
);
  logic [5:0] sr, sv;
  logic [6:0] w;
  // sr[5] is the most recent past bit; clr makes this bit see an all-zero history
  always_comb begin
    sv = clr ? 6'd0 : sr;
    w = {u, sv};
    a = ^(w & G0);
    b = ^(w & G1);
  end
  // shift the current bit in on every encoded bit
  always_ff @(posedge clk)
    sr <= rst ? 6'd0 : en ? {u, sv[5:1]} : sr;
endmodule

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: punctured K=7 convolutional encoder with optional zero tail
module conv_encoder_tx
  import ofdm_tx_pkg::*;
#(
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, RUN, TAIL, DRAIN} state_e;
  state_e state;
  logic [1:0] rq, pq, cnt, r, pe, km, cnt_n;
  logic [2:0] tcnt;
  logic hb0, hb1, hl, a, b, ld, pop, acc, tld, enc, start, u, is_last;
  conv_enc_core core (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .en (enc),
    .u  (u),
    .a  (a),
    .b  (b)
  );
  // handshake, encode source selection and puncture decision for this cycle
  always_comb begin
    pop = cnt != 2'd0 && out_ready;
    ld = cnt == 2'd0 || (cnt == 2'd1 && out_ready);
    in_ready = !rst && (state == IDLE || state == RUN) && ld;
    acc = in_valid && in_ready;
    tld = state == TAIL && ld;
    enc = acc || tld;
    start = acc && state == IDLE;
    u = acc && in_bit;
    r = start ? rate : rq;
    pe = start ? 2'd0 : pq;
    km = keep_mask(r, pe);
    is_last = tld ? tcnt == 3'(TAIL_LEN - 1) : (in_last && !TAIL_EN);
    cnt_n = enc ? ((km == 2'b11) ? 2'd2 : 2'd1) : pop ? cnt - 2'd1 : cnt;
    out_valid = cnt != 2'd0;
    out_bit = hb0;
    out_last = hl && cnt == 2'd1;
    busy = state != IDLE || cnt != 2'd0;
  end
  // frame FSM, puncture phase, tail counter and holding register
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rq <= 2'd0;
      pq <= 2'd0;
      cnt <= 2'd0;
      tcnt <= 3'd0;
      hb0 <= 1'b0;
      hb1 <= 1'b0;
      hl <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (enc) begin
        hb0 <= km[1] ? a : b;
        hb1 <= b;
        hl <= is_last;
        pq <= (pe == phase_last(r)) ? 2'd0 : pe + 2'd1;
      end else if (pop) begin
        hb0 <= hb1;
        hb1 <= 1'b0;
      end
      if (start) rq <= rate;
      case (state)
        IDLE, RUN: if (acc) state <= in_last ? (TAIL_EN ? TAIL : DRAIN) : RUN;
        TAIL: if (tld) begin
          tcnt <= (tcnt == 3'(TAIL_LEN - 1)) ? 3'd0 : tcnt + 3'd1;
          if (tcnt == 3'(TAIL_LEN - 1)) state <= DRAIN;
        end
        DRAIN: if (cnt_n == 2'd0) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: randomized self-checking bench against a tap-equation reference model
module tb_conv_encoder_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rate = 2'd0;
  logic in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic in_ready0, out_valid0, out_bit0, out_last0, busy0;
  logic in_ready1, out_valid1, out_bit1, out_last1, busy1;
  int checks = 0, errors = 0;
  bit dq[$], got[$], exp_q[$], uq[$];
  int nlast, lastpos, stall_bad, timeout;
  always #5 clk = ~clk;
  conv_encoder_tx #(.TAIL_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .rate(rate), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_bit(out_bit0), .out_last(out_last0), .busy(busy0)
  );
  conv_encoder_tx #(.TAIL_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .rate(rate), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_bit(out_bit1), .out_last(out_last1), .busy(busy1)
  );
  function automatic bit ub(input int k);
    return (k >= 0) ? uq[k] : 1'b0;
  endfunction
  task automatic build_exp(input logic [1:0] r, input bit tail);
    int m;
    bit a, b;
    uq = dq;
    if (tail) repeat (6) uq.push_back(1'b0);
    m = (r == 2'd1) ? 2 : (r == 2'd2) ? 3 : 1;
    exp_q.delete();
    for (int n = 0; n < uq.size(); n++) begin
      a = ub(n) ^ ub(n - 2) ^ ub(n - 3) ^ ub(n - 5) ^ ub(n - 6);
      b = ub(n) ^ ub(n - 1) ^ ub(n - 2) ^ ub(n - 3) ^ ub(n - 6);
      if (n % m != 2) exp_q.push_back(a);
      if (n % m != 1) exp_q.push_back(b);
    end
  endtask
  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] != exp_q[i]) return i;
    return (got.size() == exp_q.size()) ? -1 : exp_q.size();
  endfunction
  task automatic rand_data(input int n);
    dq.delete();
    repeat (n) dq.push_back(1'($urandom));
  endtask
  task automatic run_frame(input bit sel, input logic [1:0] r, input int rdy_pct, input int budget);
    int i, cyc;
    bit v, pv, pb, pl, prdy, ov, ob, ol, ir;
    i = 0; cyc = 0; pv = 0; pb = 0; pl = 0; prdy = 1;
    got.delete(); nlast = 0; lastpos = -1; stall_bad = 0; timeout = 0;
    while (cyc < budget) begin
      v = i < dq.size();
      in_valid0 = v && !sel;
      in_valid1 = v && sel;
      in_bit = v ? dq[i] : 1'b0;
      in_last = v && i == dq.size() - 1;
      rate = (i == 0) ? r : 2'($urandom_range(3));
      out_ready = $urandom_range(99) < rdy_pct;
      #1;
      ir = sel ? in_ready1 : in_ready0;
      ov = sel ? out_valid1 : out_valid0;
      ob = sel ? out_bit1 : out_bit0;
      ol = sel ? out_last1 : out_last0;
      if (pv && !prdy && (!ov || ob != pb || ol != pl)) stall_bad++;
      if (v && ir) i++;
      if (ov && out_ready) begin
        got.push_back(ob);
        if (ol) begin nlast++; lastpos = got.size() - 1; end
      end
      pv = ov; pb = ob; pl = ol; prdy = out_ready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (i == dq.size() && !(sel ? busy1 : busy0)) break;
    end
    timeout = cyc >= budget;
    in_valid0 = 0; in_valid1 = 0; in_last = 0; in_bit = 0; out_ready = 1;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready0 got=%b exp=0", in_ready0); end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready1 got=%b exp=0", in_ready1); end
    rst = 0;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready0); end
    checks++; if ({out_valid0, out_bit0, out_last0, busy0} !== 4'b0) begin
      errors++; $display("FAIL post_reset_outputs got=%b exp=0000", {out_valid0, out_bit0, out_last0, busy0}); end
    checks++; if ({in_ready1, out_valid1, busy1} !== 3'b100) begin
      errors++; $display("FAIL post_reset_dut1 got=%b exp=100", {in_ready1, out_valid1, busy1}); end
    @(negedge clk);
  endtask
  task automatic test_impulse(input string nm);
    logic [13:0] gold;
    int d;
    gold = 14'b11011111001011;
    dq = {1'b1};
    run_frame(0, 2'd0, 100, 200);
    checks++; if (timeout) begin errors++; $display("FAIL %s_busy_fall timeout=%0d exp=0", nm, timeout); end
    checks++; if (got.size() != 14) begin errors++; $display("FAIL %s_len got=%0d exp=14", nm, got.size()); end
    d = -1;
    for (int i = 0; i < 14; i++) if (d < 0 && (i >= got.size() || got[i] != gold[13 - i])) d = i;
    checks++; if (d >= 0) begin errors++; $display("FAIL %s_bits got=%p exp=%b", nm, got, gold); end
    checks++; if (nlast != 1 || lastpos != 13) begin
      errors++; $display("FAIL %s_last got=%0d/%0d exp=1/13", nm, nlast, lastpos); end
  endtask
  task automatic test_rate34();
    dq = {1'b1, 1'b0, 1'b1};
    build_exp(2'd2, 1);
    run_frame(0, 2'd2, 100, 200);
    checks++; if (got.size() != 12) begin errors++; $display("FAIL r34_len got=%0d exp=12", got.size()); end
    checks++; if (first_diff() >= 0) begin errors++; $display("FAIL r34_bits got=%p exp=%p", got, exp_q); end
    checks++; if (nlast != 1 || lastpos != 11) begin
      errors++; $display("FAIL r34_last got=%0d/%0d exp=1/11", nlast, lastpos); end
  endtask
  task automatic test_rate23();
    rand_data(4);
    build_exp(2'd1, 1);
    run_frame(0, 2'd1, 80, 300);
    checks++; if (got.size() != 15) begin errors++; $display("FAIL r23_len got=%0d exp=15", got.size()); end
    checks++; if (first_diff() >= 0) begin errors++; $display("FAIL r23_bits got=%p exp=%p", got, exp_q); end
    checks++; if (nlast != 1 || lastpos != 14) begin
      errors++; $display("FAIL r23_last got=%0d/%0d exp=1/14", nlast, lastpos); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL r23_stall got=%0d exp=0", stall_bad); end
  endtask
  task automatic test_backpressure();
    rand_data(200);
    build_exp(2'd0, 1);
    run_frame(0, 2'd0, 55, 5000);
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (first_diff() >= 0) begin
      errors++; $display("FAIL bp_bits first_bad=%0d got_len=%0d exp_len=%0d", first_diff(), got.size(), exp_q.size()); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall got=%0d exp=0", stall_bad); end
    checks++; if (nlast != 1 || lastpos != 411) begin
      errors++; $display("FAIL bp_last got=%0d/%0d exp=1/411", nlast, lastpos); end
  endtask
  task automatic test_back_to_back();
    rand_data(3);
    build_exp(2'd0, 0);
    run_frame(1, 2'd0, 100, 200);
    checks++; if (first_diff() >= 0 || got.size() != 6) begin
      errors++; $display("FAIL notail_bits got=%p exp=%p", got, exp_q); end
    checks++; if (nlast != 1 || lastpos != 5) begin
      errors++; $display("FAIL notail_last got=%0d/%0d exp=1/5", nlast, lastpos); end
    rand_data(7);
    build_exp(2'd2, 0);
    run_frame(1, 2'd2, 70, 300);
    checks++; if (first_diff() >= 0) begin errors++; $display("FAIL b2b_bits got=%p exp=%p", got, exp_q); end
    checks++; if (nlast != 1 || lastpos != exp_q.size() - 1) begin
      errors++; $display("FAIL b2b_last got=%0d/%0d exp=1/%0d", nlast, lastpos, exp_q.size() - 1); end
  endtask
  task automatic test_random_frames();
    logic [1:0] r;
    for (int f = 0; f < 6; f++) begin
      r = 2'($urandom_range(3));
      rand_data($urandom_range(1, 20));
      build_exp(r, 1);
      run_frame(0, r, 70, 400);
      checks++; if (first_diff() >= 0 || stall_bad != 0 || nlast != 1 || lastpos != exp_q.size() - 1) begin
        errors++;
        $display("FAIL rand_frame%0d rate=%0d got=%p exp=%p stall=%0d last=%0d/%0d", f, r, got, exp_q, stall_bad, nlast, lastpos);
      end
    end
  endtask
  task automatic test_rst_mid_tail();
    rate = 2'd0; out_ready = 1; in_bit = 1; in_last = 1; in_valid0 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid0 = 0; in_last = 0; in_bit = 0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_tail_busy got=%b exp=1", busy0); end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL rst_abort got=%b%b exp=00", out_valid0, busy0); end
    @(negedge clk);
    test_impulse("impulse_after_rst");
  endtask
  initial begin
    test_reset();
    test_impulse("impulse");
    test_rate34();
    test_rate23();
    test_backpressure();
    test_back_to_back();
    test_random_frames();
    test_rst_mid_tail();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
